// File: rtl/alu_sequencer_if.sv
// +--------------------------------------------------------------------+
// | alu_sequencer_if : instruction, register-file, ALU and MUL/DIV bus |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

interface alu_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_code;
    logic [5:0]  rf_raddr_a;
    logic [5:0]  rf_raddr_b;
    logic [15:0] rf_rdata_a;
    logic [15:0] rf_rdata_b;
    logic [5:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic        mc_start;
    logic        mc_done;
    logic [31:0] mc_result;
    logic        rf_we;
    logic [5:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        busy;
    logic        err;

    modport master (
        input  in_valid, in_code, rf_rdata_a, rf_rdata_b, alu_result, mc_done, mc_result,
        output in_ready, rf_raddr_a, rf_raddr_b, alu_op, alu_a, alu_b, mc_start,
               rf_we, rf_waddr, rf_wdata, busy, err
    );

    modport slave (
        output in_valid, in_code, rf_rdata_a, rf_rdata_b, alu_result, mc_done, mc_result,
        input  in_ready, rf_raddr_a, rf_raddr_b, alu_op, alu_a, alu_b, mc_start,
               rf_we, rf_waddr, rf_wdata, busy, err
    );
endinterface

`default_nettype wire

// File: rtl/alu_sequencer.sv
// +--------------------------------------------------------------------+
// | alu_sequencer : one-at-a-time read/execute/writeback controller    |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_sequencer #(
    parameter int MC_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,
    alu_sequencer_if.master bus
);

    localparam int TW = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(MC_TIMEOUT - 1);

    localparam logic [5:0] OP_ADD  = 6'h04;
    localparam logic [5:0] OP_SUB  = 6'h05;
    localparam logic [5:0] OP_NEG  = 6'h06;
    localparam logic [5:0] OP_MUL  = 6'h07;
    localparam logic [5:0] OP_DIV  = 6'h08;
    localparam logic [5:0] OP_OR   = 6'h09;
    localparam logic [5:0] OP_XOR  = 6'h0A;
    localparam logic [5:0] OP_NAND = 6'h0B;
    localparam logic [5:0] OP_NOR  = 6'h0C;
    localparam logic [5:0] OP_XNOR = 6'h0D;
    localparam logic [5:0] OP_NOT  = 6'h0E;
    localparam logic [5:0] OP_LLSH = 6'h0F;
    localparam logic [5:0] OP_LRSH = 6'h10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_WAIT = 3'd3,
        S_WB1  = 3'd4,
        S_WB2  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [5:0]      op_q, op_d;
    logic [5:0]      rdst1_q, rdst1_d;
    logic [5:0]      rdst2_q, rdst2_d;
    logic [5:0]      rsrc1_q, rsrc1_d;
    logic [5:0]      rsrc2_q, rsrc2_d;
    logic [15:0]     a_q, a_d;
    logic [15:0]     b_q, b_d;
    logic [31:0]     result_q, result_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            err_q, err_d;
    logic            ready_q;
    logic            busy_q;
    logic            w_mc_start;
    logic            w_accept;
    logic            w_unused;

    assign w_accept = ready_q & bus.in_valid;
    assign w_unused = ^bus.in_code[1:0];

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rdst1_d    = rdst1_q;
        rdst2_d    = rdst2_q;
        rsrc1_d    = rsrc1_q;
        rsrc2_d    = rsrc2_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        tmo_d      = tmo_q;
        err_d      = 1'b0;
        w_mc_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    op_d    = bus.in_code[31:26];
                    rdst1_d = bus.in_code[25:20];
                    rdst2_d = bus.in_code[19:14];
                    rsrc1_d = bus.in_code[13:8];
                    rsrc2_d = bus.in_code[7:2];
                    state_d = S_READ;
                end
            end
            S_READ: begin
                a_d     = bus.rf_rdata_a;
                b_d     = bus.rf_rdata_b;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                tmo_d = '0;
                case (op_q)
                    OP_MUL: begin
                        w_mc_start = 1'b1;
                        state_d    = S_WAIT;
                    end
                    OP_DIV: begin
                        // Divide-by-zero never reaches the multi-cycle unit
                        if (b_q == 16'd0) begin
                            result_d = 32'h0000_FFFF;
                            err_d    = 1'b1;
                            state_d  = S_WB1;
                        end else begin
                            w_mc_start = 1'b1;
                            state_d    = S_WAIT;
                        end
                    end
                    OP_ADD, OP_SUB, OP_NEG, OP_OR, OP_XOR, OP_NAND, OP_NOR,
                    OP_XNOR, OP_NOT, OP_LLSH, OP_LRSH: begin
                        result_d = {16'h0000, bus.alu_result};
                        state_d  = S_WB1;
                    end
                    default: begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                endcase
            end
            S_WAIT: begin
                if (bus.mc_done) begin
                    result_d = bus.mc_result;
                    state_d  = S_WB1;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_WB1:   state_d = (op_q == OP_MUL) ? S_WB2 : S_IDLE;
            S_WB2:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            rdst1_q  <= '0;
            rdst2_q  <= '0;
            rsrc1_q  <= '0;
            rsrc2_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rdst1_q  <= rdst1_d;
            rdst2_q  <= rdst2_d;
            rsrc1_q  <= rsrc1_d;
            rsrc2_q  <= rsrc2_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            ready_q  <= (state_d == S_IDLE);
            busy_q   <= (state_d != S_IDLE);
        end
    end

    // Addresses bypass to the incoming fields so the synchronous RF read
    // lands during READ.
    assign bus.rf_raddr_a = w_accept ? bus.in_code[13:8] : rsrc1_q;
    assign bus.rf_raddr_b = w_accept ? bus.in_code[7:2]  : rsrc2_q;

    assign bus.in_ready = ready_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;
    assign bus.alu_op   = op_q;
    assign bus.alu_a    = a_q;
    assign bus.alu_b    = b_q;
    assign bus.mc_start = w_mc_start;

    assign bus.rf_we    = (state_q == S_WB1) || (state_q == S_WB2);
    assign bus.rf_waddr = (state_q == S_WB1) ? rdst1_q :
                          (state_q == S_WB2) ? rdst2_q : 6'd0;
    assign bus.rf_wdata = (state_q == S_WB1) ? result_q[15:0] :
                          (state_q == S_WB2) ? result_q[31:16] : 16'd0;

endmodule

`default_nettype wire
